// File: rtl/jpeg_zz_pkg.sv
// Shared types and the zigzag lookup table for the JPEG coefficient reorder block.
package jpeg_zz_pkg;

  localparam int BLK_SIZE = 64;

  typedef logic signed [7:0] coef_t;
  typedef logic signed [8:0] coef_out_t;

  // Entry k is the raster index (8*row + col) of zigzag position k.
  localparam logic [5:0] ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: raster-order int8 in, zigzag-order 9-bit out.
// Optional DC DPCM on zigzag index 0 is enabled by defining ZIGZAG_DC_DPCM_EN.
import jpeg_zz_pkg::*;

module zigzag_reorder #(
  parameter int NUM_BANKS = 2,
  parameter int DOUT_W    = 9
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic signed [7:0]        din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic                     overflow
);

  coef_t                bank_q [NUM_BANKS][BLK_SIZE];
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [5:0]           wr_cnt_q, wr_cnt_d;
  logic [5:0]           rd_cnt_q, rd_cnt_d;
  coef_out_t            dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 dout_last_q, dout_last_d;
  logic                 overflow_q, overflow_d;

  logic      wr_fire;
  logic      rd_load;
  logic      bank_free;
  coef_t     rd_raw;
  coef_out_t rd_ext;

`ifdef ZIGZAG_DC_DPCM_EN
  coef_t dc_pred_q, dc_pred_d;
`endif

  always_comb begin
    bank_free = !full_q[wr_bank_q];
    wr_fire   = din_valid && bank_free;
    // Load into the output register when it is empty or being drained this cycle.
    rd_load   = (!dout_valid_q || dout_ready) && full_q[rd_bank_q];
    rd_raw    = bank_q[rd_bank_q][ZZ_LUT[rd_cnt_q]];
    rd_ext    = {rd_raw[7], rd_raw};
  end

  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    overflow_d   = overflow_q;
`ifdef ZIGZAG_DC_DPCM_EN
    dc_pred_d    = dc_pred_q;
`endif

    if (din_valid && !bank_free) begin
      overflow_d = 1'b1;
    end

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (rd_load) begin
      dout_valid_d = 1'b1;
      dout_d       = rd_ext;
      dout_last_d  = (rd_cnt_q == 6'd63);
      rd_cnt_d     = rd_cnt_q + 6'd1;
`ifdef ZIGZAG_DC_DPCM_EN
      if (rd_cnt_q == 6'd0) begin
        dout_d    = rd_ext - {dc_pred_q[7], dc_pred_q};
        dc_pred_d = rd_raw;
      end
`endif
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef ZIGZAG_DC_DPCM_EN
      dc_pred_q    <= '0;
`endif
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      overflow_q   <= overflow_d;
`ifdef ZIGZAG_DC_DPCM_EN
      dc_pred_q    <= dc_pred_d;
`endif
    end
  end

  // Bank storage is deliberately left unreset; the full flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_q[wr_bank_q][wr_cnt_q] <= din;
    end
  end

  assign din_ready  = bank_free;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_zigzag_reorder.sv
// Scoreboard bench for zigzag_reorder; expected zigzag order is generated by a diagonal walk.
module tb_zigzag_reorder;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic signed [7:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic signed [8:0] dout;
  logic              dout_valid;
  logic              dout_ready = 1'b1;
  logic              dout_last;
  logic              overflow;

  int         tests_run = 0;
  int         fails = 0;
  logic [9:0] exp_q [$];
  int         zz_tab [64];
  int         dc_pred = 0;
  bit         rand_mode = 1'b0;
  bit         ready_fixed = 1'b1;

  zigzag_reorder dut (
    .clk        (clk),
    .nrst       (nrst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    dout_ready = rand_mode ? ($urandom_range(0, 1) == 1) : ready_fixed;
  end

  // Output monitor: pops the scoreboard on every handshake and checks stall stability.
  bit               stall_q = 1'b0;
  logic signed [8:0] held_d;
  logic              held_l;
  logic [9:0]        got_e;
  logic [9:0]        exp_e;
  always @(negedge clk) begin
    if (!nrst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== held_d || dout_last !== held_l) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b dout=%0d last=%b, want valid=1 dout=%0d last=%b",
                   dout_valid, dout, dout_last, held_d, held_l);
        end
      end
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
        tests_run++;
        got_e = {dout_last, dout};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got dout=%0d last=%b, want no output", dout, dout_last);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            fails++;
            $display("FAIL dout_order: got dout=%0d last=%b, want dout=%0d last=%b",
                     dout, dout_last, $signed(exp_e[8:0]), exp_e[9]);
          end
        end
      end
      stall_q = (dout_valid === 1'b1) && (dout_ready === 1'b0);
      held_d  = dout;
      held_l  = dout_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_zz();
    int r = 0;
    int c = 0;
    for (int k = 0; k < 64; k++) begin
      zz_tab[k] = 8 * r + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    dc_pred = 0;
    nrst = 1'b1;
  endtask

  task automatic push_expected(input int vals [64]);
    int v;
    logic [8:0] v9;
    for (int k = 0; k < 64; k++) begin
      v = vals[zz_tab[k]];
`ifdef ZIGZAG_DC_DPCM_EN
      if (k == 0) begin
        v = v - dc_pred;
        dc_pred = vals[0];
      end
`endif
      v9 = v[8:0];
      exp_q.push_back({(k == 63), v9});
    end
  endtask

  task automatic drive_block(input int vals [64], input int n, input bit chk_ready);
    int v;
    for (int i = 0; i < n; i++) begin
      v = vals[i];
      din = v[7:0];
      din_valid = 1'b1;
      if (chk_ready) begin
        tests_run++;
        if (din_ready !== 1'b1) begin
          fails++;
          $display("FAIL din_ready_open: got %b at input %0d, want 1", din_ready, i);
        end
      end
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic rand_block(output int vals [64]);
    for (int i = 0; i < 64; i++) vals[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d outputs outstanding, want 0", name, exp_q.size());
    end
    tests_run++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: got dout_valid=%b after drain, want 0", name, dout_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || dout !== 9'sd0 ||
        overflow !== 1'b0 || din_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got valid=%b last=%b dout=%0d ovf=%b rdy=%b, want 0 0 0 0 1",
               dout_valid, dout_last, dout, overflow, din_ready);
    end
  endtask

  task automatic test_raster();
    int vals [64];
    for (int i = 0; i < 64; i++) vals[i] = i;
    ready_fixed = 1'b1;
    push_expected(vals);
    drive_block(vals, 64, 1'b1);
    tests_run++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: got dout_valid=%b right after 64th input, want 0", dout_valid);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (dout_valid !== 1'b1 || dout !== 9'sd0) begin
      fails++;
      $display("FAIL latency_first: got valid=%b dout=%0d one cycle later, want valid=1 dout=0",
               dout_valid, dout);
    end
    wait_drain(200, "raster");
  endtask

  task automatic test_back_to_back();
    int a [64];
    int b [64];
    int c [64];
    rand_block(a);
    rand_block(b);
    rand_block(c);
    push_expected(a);
    push_expected(b);
    push_expected(c);
    drive_block(a, 64, 1'b1);
    drive_block(b, 64, 1'b1);
    drive_block(c, 64, 1'b1);
    wait_drain(300, "b2b");
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_overflow: got %b, want 0", overflow);
    end
  endtask

  task automatic test_stall();
    int a [64];
    int b [64];
    rand_block(a);
    rand_block(b);
    push_expected(a);
    push_expected(b);
    rand_mode = 1'b1;
    drive_block(a, 64, 1'b1);
    drive_block(b, 64, 1'b1);
    wait_drain(2000, "stall");
    rand_mode = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL stall_overflow: got %b, want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int a [64];
    int b [64];
    int x [64];
    do_reset();
    ready_fixed = 1'b0;
    rand_block(a);
    rand_block(b);
    rand_block(x);
    push_expected(a);
    push_expected(b);
    drive_block(a, 64, 1'b1);
    drive_block(b, 64, 1'b1);
    tests_run++;
    if (din_ready !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_banks: got din_ready=%b overflow=%b after 128 inputs, want 0 0",
               din_ready, overflow);
    end
    drive_block(x, 1, 1'b0);
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %b, want 1", overflow);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: got %b, want 1", overflow);
    end
    ready_fixed = 1'b1;
    wait_drain(300, "overflow");
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_hold: got %b after drain, want 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    int a [64];
    int b [64];
    int c [64];
    ready_fixed = 1'b1;
    rand_block(a);
    rand_block(b);
    rand_block(c);
    push_expected(a);
    drive_block(a, 64, 1'b0);
    drive_block(b, 30, 1'b0);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (dout_valid !== 1'b0 || overflow !== 1'b0 || din_ready !== 1'b1 || dout_last !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_state: got valid=%b ovf=%b rdy=%b last=%b, want 0 0 1 0",
               dout_valid, overflow, din_ready, dout_last);
    end
    exp_q.delete();
    dc_pred = 0;
    nrst = 1'b1;
    push_expected(c);
    drive_block(c, 64, 1'b1);
    wait_drain(200, "mid_reset");
    repeat (70) @(posedge clk);
    #1;
    tests_run++;
    if (dout_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_extra: got dout_valid=%b long after new block, want 0", dout_valid);
    end
  endtask

  task automatic test_dc();
    int blk [64];
    int dcs [4];
    dcs[0] = 10;
    dcs[1] = -5;
    dcs[2] = 127;
    dcs[3] = -128;
    do_reset();
    ready_fixed = 1'b1;
    for (int n = 0; n < 4; n++) begin
      rand_block(blk);
      blk[0] = dcs[n];
      push_expected(blk);
      drive_block(blk, 64, 1'b1);
    end
    wait_drain(400, "dc");
  endtask

  initial begin
    build_zz();
    test_reset();
    test_raster();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_dc();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
